// File: rtl/router_pkg.sv
// Shared router definitions: default port count, port-index type and the
// per-output lock state used by the output arbiters.
package router_pkg;

    localparam int N_PORTS_DEF = 16;
    localparam int ADDR_W_DEF  = $clog2(N_PORTS_DEF);

    typedef logic [ADDR_W_DEF-1:0] port_idx_t;

    typedef enum logic {
        OUT_IDLE   = 1'b0,
        OUT_LOCKED = 1'b1
    } out_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or above ptr,
// wrapping from N-1 back to 0, wins. Grant is one-hot plus its index.
module rr_arbiter #(
    parameter int N     = 16,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [PTR_W-1:0] grant_idx,
    output logic             found
);

    logic [PTR_W:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            // ptr + k stays below 2N, so a single conditional subtract wraps it
            cand = {1'b0, ptr} + (PTR_W+1)'(k);
            if (cand >= (PTR_W+1)'(N)) begin
                cand = cand - (PTR_W+1)'(N);
            end
            if (!found && req[cand[PTR_W-1:0]]) begin
                found                  = 1'b1;
                grant[cand[PTR_W-1:0]] = 1'b1;
                grant_idx              = cand[PTR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/output_port_arbiter.sv
// Per-output packet-locked round-robin arbiter for the N x N crossbar: each
// output locks to one input from grant until that input's tail beat or abort.
module output_port_arbiter
    import router_pkg::*;
#(
    parameter int N_PORTS = N_PORTS_DEF,
    parameter int ADDR_W  = $clog2(N_PORTS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_PORTS-1:0]          req_valid,
    input  logic [N_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [N_PORTS-1:0]          req_last,
    input  logic [N_PORTS-1:0]          xfer,
    output logic [N_PORTS-1:0]          in_grant,
    output logic [N_PORTS-1:0]          in_busy,
    output logic [N_PORTS-1:0]          out_busy,
    output logic [N_PORTS*ADDR_W-1:0]   out_owner
);

    out_state_t         state_q [N_PORTS];
    logic [ADDR_W-1:0]  owner_q [N_PORTS];
    logic [ADDR_W-1:0]  ptr_q   [N_PORTS];
    logic [N_PORTS-1:0] grant_q;

    logic [ADDR_W-1:0]  addr    [N_PORTS];
    logic [N_PORTS-1:0] addr_ok;
    logic [N_PORTS-1:0] req_mat [N_PORTS];
    logic [N_PORTS-1:0] win_oh  [N_PORTS];
    logic [ADDR_W-1:0]  win_idx [N_PORTS];
    logic [N_PORTS-1:0] win_any;
    logic [N_PORTS-1:0] release_o;
    logic [N_PORTS-1:0] grant_set;
    logic [N_PORTS-1:0] grant_clr;

    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        if (p == ADDR_W'(N_PORTS - 1)) begin
            return '0;
        end
        return p + ADDR_W'(1);
    endfunction

    for (genvar i = 0; i < N_PORTS; i++) begin : g_port
        assign addr[i]                          = req_addr[i*ADDR_W +: ADDR_W];
        assign out_busy[i]                      = (state_q[i] == OUT_LOCKED);
        assign out_owner[i*ADDR_W +: ADDR_W]    = owner_q[i];
        if ((1 << ADDR_W) == N_PORTS) begin : g_full
            assign addr_ok[i] = 1'b1;
        end else begin : g_part
            // Addresses beyond the last port are treated as no request
            assign addr_ok[i] = (int'(addr[i]) < N_PORTS);
        end
    end

    // Inputs already holding a grant never compete for another output
    always_comb begin
        for (int j = 0; j < N_PORTS; j++) begin
            req_mat[j] = '0;
            for (int i = 0; i < N_PORTS; i++) begin
                req_mat[j][i] = req_valid[i] && addr_ok[i] && !grant_q[i]
                                && (addr[i] == ADDR_W'(j));
            end
        end
    end

    for (genvar j = 0; j < N_PORTS; j++) begin : g_arb
        rr_arbiter #(
            .N     (N_PORTS),
            .PTR_W (ADDR_W)
        ) u_rr_arbiter (
            .req       (req_mat[j]),
            .ptr       (ptr_q[j]),
            .grant     (win_oh[j]),
            .grant_idx (win_idx[j]),
            .found     (win_any[j])
        );
    end

    always_comb begin
        release_o = '0;
        grant_set = '0;
        grant_clr = '0;
        for (int j = 0; j < N_PORTS; j++) begin
            if (state_q[j] == OUT_LOCKED) begin
                if ((xfer[owner_q[j]] && req_last[owner_q[j]]) || !req_valid[owner_q[j]]) begin
                    release_o[j]          = 1'b1;
                    grant_clr[owner_q[j]] = 1'b1;
                end
            end else if (win_any[j]) begin
                grant_set = grant_set | win_oh[j];
            end
        end
    end

    always_comb begin
        in_busy = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (req_valid[i] && addr_ok[i]) begin
                in_busy[i] = out_busy[addr[i]] && (owner_q[addr[i]] != ADDR_W'(i));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q <= '0;
            for (int j = 0; j < N_PORTS; j++) begin
                state_q[j] <= OUT_IDLE;
                owner_q[j] <= '0;
                ptr_q[j]   <= '0;
            end
        end else begin
            grant_q <= (grant_q & ~grant_clr) | grant_set;
            for (int j = 0; j < N_PORTS; j++) begin
                case (state_q[j])
                    OUT_IDLE: begin
                        if (win_any[j]) begin
                            state_q[j] <= OUT_LOCKED;
                            owner_q[j] <= win_idx[j];
                            ptr_q[j]   <= ptr_inc(win_idx[j]);
                        end
                    end
                    OUT_LOCKED: begin
                        if (release_o[j]) begin
                            state_q[j] <= OUT_IDLE;
                        end
                    end
                    default: state_q[j] <= OUT_IDLE;
                endcase
            end
        end
    end

    assign in_grant = grant_q;

    a_xfer_needs_grant: assert property (@(posedge clk) disable iff (rst)
        ((xfer & ~grant_q) == '0));

endmodule

// File: tb/tb_output_port_arbiter.sv
// Scoreboard bench for output_port_arbiter: a per-output owner/pointer model
// predicts every cycle's outputs; a separate monitor pops and compares them.
module tb_output_port_arbiter;

    localparam int N  = 16;
    localparam int AW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N-1:0]    req_last = '0;
    logic [N-1:0]    xfer = '0;
    logic [N-1:0]    in_grant;
    logic [N-1:0]    in_busy;
    logic [N-1:0]    out_busy;
    logic [N*AW-1:0] out_owner;

    always #5 clk = ~clk;

    output_port_arbiter #(
        .N_PORTS (N),
        .ADDR_W  (AW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_last  (req_last),
        .xfer      (xfer),
        .in_grant  (in_grant),
        .in_busy   (in_busy),
        .out_busy  (out_busy),
        .out_owner (out_owner)
    );

    typedef struct packed {
        logic [N-1:0]    grant;
        logic [N-1:0]    busy;
        logic [N-1:0]    ibusy;
        logic [N*AW-1:0] owner;
        logic [N*AW-1:0] omask;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Stimulus intent per input; xfer is only ever applied to granted inputs
    logic         s_rst = 1'b1;
    logic [N-1:0] s_valid = '0;
    logic [N-1:0] s_last = '0;
    logic [N-1:0] s_xreq = '0;
    int           s_addr[N];

    // Reference model: owner per output (-1 when free) and RR pointer
    int m_owner[N];
    int m_ptr[N];
    bit known = 1'b0;
    bit just_reset = 1'b0;

    int cap_out = -1;
    int cap_q[$];
    bit cap_prev = 1'b0;

    task automatic check(input string name, input logic [N*AW-1:0] got, input logic [N*AW-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [N-1:0] model_grants();
        logic [N-1:0] g = '0;
        for (int j = 0; j < N; j++) begin
            if (m_owner[j] >= 0) g[m_owner[j]] = 1'b1;
        end
        return g;
    endfunction

    task automatic model_step(input logic [N-1:0] xf);
        int nown[N];
        int nptr[N];
        logic [N-1:0] g;
        g = model_grants();
        for (int j = 0; j < N; j++) begin
            nown[j] = m_owner[j];
            nptr[j] = m_ptr[j];
            if (m_owner[j] >= 0) begin
                int k = m_owner[j];
                if ((xf[k] && s_last[k]) || !s_valid[k]) nown[j] = -1;
            end else begin
                for (int d = 0; d < N; d++) begin
                    int i = (m_ptr[j] + d) % N;
                    if (s_valid[i] && s_addr[i] == j && !g[i]) begin
                        nown[j] = i;
                        nptr[j] = (i + 1) % N;
                        break;
                    end
                end
            end
        end
        m_owner = nown;
        m_ptr   = nptr;
    endtask

    task automatic tick();
        logic [N-1:0] gv;
        logic [N-1:0] xf;
        exp_t e;
        @(negedge clk);
        gv = model_grants();
        xf = s_rst ? '0 : (s_xreq & gv);
        rst       = s_rst;
        req_valid = s_valid;
        req_last  = s_last;
        xfer      = xf;
        for (int i = 0; i < N; i++) req_addr[i*AW +: AW] = AW'(s_addr[i]);
        if (known) begin
            e = '0;
            e.grant = gv;
            for (int j = 0; j < N; j++) begin
                if (m_owner[j] >= 0) begin
                    e.busy[j]             = 1'b1;
                    e.owner[j*AW +: AW]   = AW'(m_owner[j]);
                    e.omask[j*AW +: AW]   = '1;
                end
            end
            for (int i = 0; i < N; i++) begin
                int a = s_addr[i];
                e.ibusy[i] = s_valid[i] && (m_owner[a] >= 0) && (m_owner[a] != i);
            end
            if (just_reset) begin
                e.owner = '0;
                e.omask = '1;
            end
            exp_q.push_back(e);
        end
        if (s_rst) begin
            for (int j = 0; j < N; j++) begin
                m_owner[j] = -1;
                m_ptr[j]   = 0;
            end
            known      = 1'b1;
            just_reset = 1'b1;
        end else begin
            just_reset = 1'b0;
            model_step(xf);
        end
    endtask

    task automatic set_req(input int i, input int a, input bit last, input bit xr);
        s_valid[i] = 1'b1;
        s_addr[i]  = a;
        s_last[i]  = last;
        s_xreq[i]  = xr;
    endtask

    task automatic idle(input int n);
        s_valid = '0;
        s_last  = '0;
        s_xreq  = '0;
        repeat (n) tick();
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("in_grant", in_grant, e.grant);
                check("out_busy", out_busy, e.busy);
                check("out_owner", out_owner & e.omask, e.owner & e.omask);
                check("in_busy", in_busy, e.ibusy);
            end
            if (cap_out >= 0) begin
                if (out_busy[cap_out] && !cap_prev) cap_q.push_back(int'(out_owner[cap_out*AW +: AW]));
                cap_prev = out_busy[cap_out];
            end else begin
                cap_prev = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check_cap(input string name, input int want[$]);
        #3;
        check({name, "_count"}, (cap_q.size() >= want.size()), 1);
        for (int k = 0; k < want.size(); k++) begin
            if (k < cap_q.size()) check(name, cap_q[k], want[k]);
        end
        cap_out = -1;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            s_addr[i]  = 0;
            m_owner[i] = -1;
            m_ptr[i]   = 0;
        end

        // Reset held 3 cycles under random inputs
        s_rst = 1'b1;
        repeat (3) begin
            s_valid = N'($urandom);
            s_last  = N'($urandom);
            for (int i = 0; i < N; i++) s_addr[i] = $urandom_range(N-1);
            tick();
        end
        s_rst = 1'b0;
        idle(2);

        // Single multi-beat packet in2 -> out5
        set_req(2, 5, 1'b0, 1'b1);
        tick(); tick(); tick();
        s_last[2] = 1'b1;
        tick();
        idle(3);

        // Contention on out7 with single-beat packets
        cap_q.delete();
        cap_out = 7;
        set_req(0, 7, 1'b1, 1'b1);
        set_req(3, 7, 1'b1, 1'b1);
        set_req(9, 7, 1'b1, 1'b1);
        repeat (9) tick();
        idle(2);
        check_cap("order7", '{0, 3, 9, 0});

        // Parallel grants, independent tails
        set_req(1, 4, 1'b0, 1'b1);
        set_req(6, 8, 1'b0, 1'b1);
        tick(); tick();
        s_last[1] = 1'b1;
        tick();
        s_valid[1] = 1'b0;
        s_last[6]  = 1'b1;
        tick();
        idle(3);

        // Abort then wrapped pointer on out0
        cap_q.delete();
        cap_out = 0;
        set_req(15, 0, 1'b0, 1'b1);
        tick(); tick(); tick();
        s_valid[15] = 1'b0;
        tick();
        set_req(15, 0, 1'b0, 1'b1);
        set_req(1, 0, 1'b0, 1'b1);
        tick(); tick(); tick();
        idle(2);
        check_cap("wrap0", '{15, 1});

        // Reset mid-packet on out2
        cap_q.delete();
        cap_out = 2;
        set_req(4, 2, 1'b0, 1'b1);
        tick(); tick(); tick();
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        set_req(7, 2, 1'b0, 1'b1);
        tick(); tick(); tick();
        idle(2);
        check_cap("rst2", '{4, 4});

        // Random traffic with aborts, address churn and occasional reset
        for (int c = 0; c < 3000; c++) begin
            s_rst = ($urandom_range(249) == 0);
            for (int i = 0; i < N; i++) begin
                if (!s_valid[i]) begin
                    if ($urandom_range(3) == 0) begin
                        s_valid[i] = 1'b1;
                        s_addr[i]  = $urandom_range(N-1);
                    end
                end else if ($urandom_range(19) == 0) begin
                    s_valid[i] = 1'b0;
                end else if ($urandom_range(15) == 0) begin
                    s_addr[i] = $urandom_range(N-1);
                end
                s_last[i] = ($urandom_range(3) == 0);
                s_xreq[i] = $urandom_range(1);
            end
            tick();
        end
        s_rst = 1'b0;
        idle(3);

        repeat (5) begin
            if (exp_q.size() > 0) @(negedge clk);
        end
        #3;
        check("drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
